// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side front end of the register file; arbitrates ALU and buffered LSU results onto one write port
// Optional macro REGFILE_WB_BYPASS_EN adds a combinational read bypass from the registered write port.
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   unbuffered ALU result channel
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   load result channel, buffered in a FIFO
//   rf_we/rf_waddr/rf_wdata       registered register-file write port
//   fifo_count                    LSU FIFO occupancy
//   idle                          FIFO empty and no write in flight
//   byp_rs{1,2}_addr/_hit/_data   bypass lookup (REGFILE_WB_BYPASS_EN only)
module regfile_writeback #(
    parameter int XLEN           = 32,
    parameter int LSU_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [4:0]                        alu_rd,
    input  logic [XLEN-1:0]                   alu_data,
    input  logic                              lsu_valid,
    output logic                              lsu_ready,
    input  logic [4:0]                        lsu_rd,
    input  logic [XLEN-1:0]                   lsu_data,
    output logic                              rf_we,
    output logic [4:0]                        rf_waddr,
    output logic [XLEN-1:0]                   rf_wdata,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [4:0]                        byp_rs1_addr,
    input  logic [4:0]                        byp_rs2_addr,
    output logic                              byp_rs1_hit,
    output logic                              byp_rs2_hit,
    output logic [XLEN-1:0]                   byp_rs1_data,
    output logic [XLEN-1:0]                   byp_rs2_data,
`endif
    output logic                              idle
);

    localparam int PW = $clog2(LSU_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = 5 + XLEN;

    logic [EW-1:0]   mem_q [LSU_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic            empty, full, force_lsu, alu_acc, pop, push, sel_valid;
    logic [EW-1:0]   head;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        empty      = count_q == '0;
        full       = count_q == CW'(LSU_FIFO_DEPTH);
        // A starved, non-empty FIFO pre-empts the ALU for one cycle.
        force_lsu  = (starve_q == SW'(STARVE_LIMIT)) && !empty;
        alu_ready  = rst_n && !force_lsu;
        lsu_ready  = !full;
        alu_acc    = alu_valid && !force_lsu;
        pop        = !empty && (force_lsu || !alu_valid);
        // Fullness comes from the registered count only: a same-cycle pop never frees a slot.
        push       = lsu_valid && !full;
        head       = mem_q[rd_ptr_q];
        sel_valid  = pop || alu_acc;
        sel_rd     = pop ? head[EW-1 -: 5] : alu_rd;
        sel_data   = pop ? head[XLEN-1:0] : alu_data;
        // x0 results complete their handshake but never reach the register file.
        rf_we_d    = sel_valid && (sel_rd != 5'd0);
        rf_waddr_d = rf_we_d ? sel_rd : rf_waddr_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        // A non-empty FIFO that was not popped lost to the ALU this cycle.
        starve_d   = (empty || pop) ? '0 :
                     (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Storage needs no reset: entries are only visible through the reset pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {lsu_rd, lsu_data};
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;
    assign idle       = empty && !rf_we_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_rs1_hit  = rf_we_q && (rf_waddr_q == byp_rs1_addr) && (byp_rs1_addr != 5'd0);
    assign byp_rs2_hit  = rf_we_q && (rf_waddr_q == byp_rs2_addr) && (byp_rs2_addr != 5'd0);
    assign byp_rs1_data = byp_rs1_hit ? rf_wdata_q : '0;
    assign byp_rs2_data = byp_rs2_hit ? rf_wdata_q : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized and directed bench for regfile_writeback against a queue-based reference model
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int LIM   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, rf_we, idle;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  byp_rs1_addr = '0, byp_rs2_addr = '0;
    logic        byp_rs1_hit, byp_rs2_hit;
    logic [31:0] byp_rs1_data, byp_rs2_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [36:0] q[$];
    int          starve = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic        last_forced = 1'b0;

    regfile_writeback #(.XLEN(32), .LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fifo_count(fifo_count),
`ifdef REGFILE_WB_BYPASS_EN
        .byp_rs1_addr(byp_rs1_addr), .byp_rs2_addr(byp_rs2_addr),
        .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit),
        .byp_rs1_data(byp_rs1_data), .byp_rs2_data(byp_rs2_data),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    endtask

    // One clock: check the handshake outputs, advance the model, then check registered outputs after the edge.
    task automatic step();
        int          sz;
        logic        frc, pop, acc;
        logic [36:0] e;
        logic [4:0]  srd;
        logic [31:0] sdat;
        sz  = q.size();
        frc = (starve == LIM) && (sz > 0);
        last_forced = frc;
        check("alu_ready", alu_ready, !frc);
        check("lsu_ready", lsu_ready, sz < DEPTH);
        acc = alu_valid && !frc;
        pop = (sz > 0) && (frc || !alu_valid);
        if (pop) begin
            e    = q.pop_front();
            srd  = e[36:32];
            sdat = e[31:0];
        end else begin
            srd  = alu_rd;
            sdat = alu_data;
        end
        starve = (sz == 0 || pop) ? 0 : (starve < LIM ? starve + 1 : starve);
        if (lsu_valid && sz < DEPTH) q.push_back({lsu_rd, lsu_data});
        m_we = (pop || acc) && (srd != 0);
        if (m_we) begin
            m_waddr = srd;
            m_wdata = sdat;
        end
        @(posedge clk);
        #1;
        check("rf_we", rf_we, m_we);
        check("rf_waddr", rf_waddr, m_waddr);
        check("rf_wdata", rf_wdata, m_wdata);
        check("fifo_count", fifo_count, q.size());
        check("idle", idle, q.size() == 0 && !m_we);
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_rs1_hit", byp_rs1_hit, m_we && m_waddr == byp_rs1_addr && byp_rs1_addr != 0);
        check("byp_rs2_hit", byp_rs2_hit, m_we && m_waddr == byp_rs2_addr && byp_rs2_addr != 0);
        check("byp_rs1_data", byp_rs1_data, (m_we && m_waddr == byp_rs1_addr && byp_rs1_addr != 0) ? m_wdata : 32'h0);
        check("byp_rs2_data", byp_rs2_data, (m_we && m_waddr == byp_rs2_addr && byp_rs2_addr != 0) ? m_wdata : 32'h0);
`endif
    endtask

    // Assert reset mid-cycle, verify the immediate effect, release on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        starve  = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_lsu_ready", lsu_ready, 1);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_idle", idle, 1);
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int peak;
        int forced;
        do_reset();

        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        check("alu_wr_we", rf_we, 1);
        check("alu_wr_addr", rf_waddr, 5);
        check("alu_wr_data", rf_wdata, 32'hDEADBEEF);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        check("alu_after_we", rf_we, 0);
        check("alu_after_idle", idle, 1);

        peak = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(0, 0, 0, 1, 5'(i + 1), 32'((i + 1) * 16));
            else set_in(0, 0, 0, 0, 0, 0);
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (i >= 1 && i <= 4) begin
                check("lsu_order_we", rf_we, 1);
                check("lsu_order_rd", rf_waddr, 5'(i));
                check("lsu_order_data", rf_wdata, 32'(i * 16));
            end
        end
        check("lsu_peak_count", peak, 1);

        forced = 0;
        for (int i = 0; i < 7; i++) begin
            set_in(1, 5'(20 + i), 32'(32'h100 + i), i == 0, 7, 32'h77);
            step();
            if (last_forced) forced++;
            if (i == 4) begin
                check("force_rd", rf_waddr, 7);
                check("force_data", rf_wdata, 32'h77);
            end
        end
        check("force_count", forced, 1);

        set_in(1, 0, 32'h1234, 1, 0, 32'h5678);
        step();
        check("x0_we_0", rf_we, 0);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        check("x0_we_1", rf_we, 0);
        check("x0_popped", fifo_count, 0);

        for (int i = 0; i < 8; i++) begin
            set_in(1, 5'(10 + i), $urandom, 1, 5'(1 + i), $urandom);
            step();
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_write", rf_we, 0);
        end

`ifdef REGFILE_WB_BYPASS_EN
        byp_rs1_addr = 9;
        byp_rs2_addr = 0;
        set_in(1, 9, 32'hCAFE, 0, 0, 0);
        step();
        check("byp_dir_hit1", byp_rs1_hit, 1);
        check("byp_dir_data1", byp_rs1_data, 32'hCAFE);
        check("byp_dir_hit2", byp_rs2_hit, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 9) < 6, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
`ifdef REGFILE_WB_BYPASS_EN
            byp_rs1_addr = ($urandom_range(0, 1) == 1) ? alu_rd : 5'($urandom);
            byp_rs2_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
`endif
            step();
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
